// File: rtl/dest_reg_tracker.sv
// dest_reg_tracker
// Carries the EX-stage destination register through the EX/MEM and MEM/WB
// stages with its write-enable and load flags. From that state it derives the
// ALU operand forwarding selects and the load-use stall request.
module dest_reg_tracker #(
  parameter int REG_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] ExWriteReg,
  input  logic             ExRegWrite,
  input  logic             ExMemRead,
  input  logic [REG_W-1:0] ExRs,
  input  logic [REG_W-1:0] ExRt,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             Stall,
  input  logic             Flush,
  output logic [REG_W-1:0] MemWriteReg,
  output logic             MemRegWrite,
  output logic             MemMemRead,
  output logic [REG_W-1:0] WbWriteReg,
  output logic             WbRegWrite,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             LoadUseStall
);

  // EX/MEM stage state
  logic [REG_W-1:0] mem_write_reg_reg, mem_write_reg_next;
  logic             mem_reg_write_reg, mem_reg_write_next;
  logic             mem_mem_read_reg,  mem_mem_read_next;

  // MEM/WB stage state (the load flag is not needed past MEM)
  logic [REG_W-1:0] wb_write_reg_reg, wb_write_reg_next;
  logic             wb_reg_write_reg, wb_reg_write_next;

  // A stage is a hazard source only when it writes a register other than r0
  logic mem_live;
  logic wb_live;

  // Per-operand forwarding: index 0 is operand A (ExRs), 1 is operand B (ExRt)
  logic [1:0][REG_W-1:0] fwd_src;
  logic [1:0]            mem_hit;
  logic [1:0]            wb_hit;
  logic [1:0][1:0]       fwd_sel;

  // Next-state selection: Stall holds everything and overrides Flush; Flush
  // bubbles EX/MEM while MEM/WB still advances.
  always_comb begin
    mem_write_reg_next = mem_write_reg_reg;
    mem_reg_write_next = mem_reg_write_reg;
    mem_mem_read_next  = mem_mem_read_reg;
    wb_write_reg_next  = wb_write_reg_reg;
    wb_reg_write_next  = wb_reg_write_reg;
    if (!Stall) begin
      wb_write_reg_next = mem_write_reg_reg;
      wb_reg_write_next = mem_reg_write_reg;
      if (Flush) begin
        mem_write_reg_next = '0;
        mem_reg_write_next = 1'b0;
        mem_mem_read_next  = 1'b0;
      end else begin
        mem_write_reg_next = ExWriteReg;
        mem_reg_write_next = ExRegWrite;
        mem_mem_read_next  = ExMemRead;
      end
    end
  end

  // Stage registers with asynchronous clear so in-flight writes are dropped at once
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_write_reg_reg <= '0;
      mem_reg_write_reg <= 1'b0;
      mem_mem_read_reg  <= 1'b0;
      wb_write_reg_reg  <= '0;
      wb_reg_write_reg  <= 1'b0;
    end else begin
      mem_write_reg_reg <= mem_write_reg_next;
      mem_reg_write_reg <= mem_reg_write_next;
      mem_mem_read_reg  <= mem_mem_read_next;
      wb_write_reg_reg  <= wb_write_reg_next;
      wb_reg_write_reg  <= wb_reg_write_next;
    end
  end

  assign mem_live = mem_reg_write_reg && (mem_write_reg_reg != '0);
  assign wb_live  = wb_reg_write_reg  && (wb_write_reg_reg  != '0);

  assign fwd_src[0] = ExRs;
  assign fwd_src[1] = ExRt;

  // Same selection rule for both operands; the younger EX/MEM result wins
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign mem_hit[gi] = mem_live && (mem_write_reg_reg == fwd_src[gi]);
      assign wb_hit[gi]  = wb_live  && (wb_write_reg_reg  == fwd_src[gi]);
      assign fwd_sel[gi] = mem_hit[gi] ? 2'b10 :
                           wb_hit[gi]  ? 2'b01 : 2'b00;
    end
  endgenerate

  assign ForwardA = fwd_sel[0];
  assign ForwardB = fwd_sel[1];

  // A load in EX whose target is read by the instruction in ID cannot be forwarded in time
  assign LoadUseStall = ExMemRead && ExRegWrite && (ExWriteReg != '0) &&
                        ((ExWriteReg == IdRs) || (ExWriteReg == IdRt));

  assign MemWriteReg = mem_write_reg_reg;
  assign MemRegWrite = mem_reg_write_reg;
  assign MemMemRead  = mem_mem_read_reg;
  assign WbWriteReg  = wb_write_reg_reg;
  assign WbRegWrite  = wb_reg_write_reg;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Testbench for dest_reg_tracker: directed scenarios plus a random run,
// with expected stage contents queued per transaction and compared after the edge.
module tb_dest_reg_tracker;

  localparam int REG_W = 5;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [REG_W-1:0] ExWriteReg = '0;
  logic             ExRegWrite = 1'b0;
  logic             ExMemRead = 1'b0;
  logic [REG_W-1:0] ExRs = '0;
  logic [REG_W-1:0] ExRt = '0;
  logic [REG_W-1:0] IdRs = '0;
  logic [REG_W-1:0] IdRt = '0;
  logic             Stall = 1'b0;
  logic             Flush = 1'b0;
  logic [REG_W-1:0] MemWriteReg;
  logic             MemRegWrite;
  logic             MemMemRead;
  logic [REG_W-1:0] WbWriteReg;
  logic             WbRegWrite;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             LoadUseStall;

  dest_reg_tracker #(.REG_W(REG_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .ExWriteReg(ExWriteReg), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExRs(ExRs), .ExRt(ExRt), .IdRs(IdRs), .IdRt(IdRt),
    .Stall(Stall), .Flush(Flush),
    .MemWriteReg(MemWriteReg), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
    .WbWriteReg(WbWriteReg), .WbRegWrite(WbRegWrite),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .LoadUseStall(LoadUseStall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [REG_W-1:0] mwr;
    logic             mwe;
    logic             mmr;
    logic [REG_W-1:0] wwr;
    logic             wwe;
  } exp_t;

  exp_t exp_q[$];

  // Reference stage state
  logic [REG_W-1:0] m_mwr = '0;
  logic             m_mwe = 1'b0;
  logic             m_mmr = 1'b0;
  logic [REG_W-1:0] m_wwr = '0;
  logic             m_wwe = 1'b0;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] src);
    if (m_mwe && m_mwr != 0 && m_mwr == src) return 2'b10;
    if (m_wwe && m_wwr != 0 && m_wwr == src) return 2'b01;
    return 2'b00;
  endfunction

  // One pipeline cycle: drive, check combinational outputs, clock, check stage regs
  task automatic drive(input logic [REG_W-1:0] wr, input logic we, input logic mr,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] idrs, input logic [REG_W-1:0] idrt,
                       input logic st, input logic fl);
    exp_t e;
    logic lus;
    ExWriteReg = wr; ExRegWrite = we; ExMemRead = mr;
    ExRs = rs; ExRt = rt; IdRs = idrs; IdRt = idrt;
    Stall = st; Flush = fl;
    #1;
    lus = mr && we && (wr != 0) && (wr == idrs || wr == idrt);
    check_val("fwd_a", 8'(ForwardA), 8'(exp_fwd(rs)));
    check_val("fwd_b", 8'(ForwardB), 8'(exp_fwd(rt)));
    check_val("load_use", 8'(LoadUseStall), 8'(lus));
    if (st) begin
      e = '{m_mwr, m_mwe, m_mmr, m_wwr, m_wwe};
    end else if (fl) begin
      e = '{'0, 1'b0, 1'b0, m_mwr, m_mwe};
    end else begin
      e = '{wr, we, mr, m_mwr, m_mwe};
    end
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check_val("mem_wr", 8'(MemWriteReg), 8'(e.mwr));
    check_val("mem_we", 8'(MemRegWrite), 8'(e.mwe));
    check_val("mem_mr", 8'(MemMemRead), 8'(e.mmr));
    check_val("wb_wr", 8'(WbWriteReg), 8'(e.wwr));
    check_val("wb_we", 8'(WbRegWrite), 8'(e.wwe));
    m_mwr = e.mwr; m_mwe = e.mwe; m_mmr = e.mmr; m_wwr = e.wwr; m_wwe = e.wwe;
    txn++;
    $display("txn %0d: ex=%0d/%0b/%0b st=%0b fl=%0b -> mem=%0d/%0b/%0b wb=%0d/%0b fa=%0b fb=%0b lus=%0b",
             txn, wr, we, mr, st, fl, MemWriteReg, MemRegWrite, MemMemRead,
             WbWriteReg, WbRegWrite, ForwardA, ForwardB, LoadUseStall);
  endtask

  // Checks outputs while Rst is held, without any clock edge in between
  task automatic check_reset_state(input string tag);
    check_val({tag, "_mem_wr"}, 8'(MemWriteReg), 8'd0);
    check_val({tag, "_mem_we"}, 8'(MemRegWrite), 8'd0);
    check_val({tag, "_mem_mr"}, 8'(MemMemRead), 8'd0);
    check_val({tag, "_wb_wr"}, 8'(WbWriteReg), 8'd0);
    check_val({tag, "_wb_we"}, 8'(WbRegWrite), 8'd0);
    check_val({tag, "_fwd_a"}, 8'(ForwardA), 8'd0);
    check_val({tag, "_fwd_b"}, 8'(ForwardB), 8'd0);
  endtask

  initial begin
    // Power-on reset
    #2;
    check_reset_state("rst0");
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Fill stages with {7,1,1} in EX/MEM and {9,1} in MEM/WB
    drive(9, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(7, 1, 1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle, with a load-use pattern on the inputs
    ExRs = 7; ExRt = 9; ExWriteReg = 7; ExRegWrite = 1; ExMemRead = 1; IdRs = 7;
    #2;
    Rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    check_val("rst_load_use", 8'(LoadUseStall), 8'd1);
    m_mwr = '0; m_mwe = 1'b0; m_mmr = 1'b0; m_wwr = '0; m_wwe = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0);

    // Forward priority on operand A, then operand B
    drive(8, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(8, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(8, 1, 0, 8, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
    drive(2, 1, 0, 8, 8, 0, 0, 0, 0);
    drive(8, 1, 0, 0, 8, 0, 0, 0, 0);
    drive(8, 1, 0, 0, 8, 0, 0, 0, 0);
    drive(4, 1, 0, 0, 8, 0, 0, 0, 0);
    drive(4, 1, 0, 8, 8, 0, 0, 0, 0);

    // Register 0 is never a hazard source
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Load-use detection
    drive(5, 1, 1, 0, 0, 0, 5, 0, 0);
    drive(5, 1, 1, 5, 5, 6, 6, 0, 0);
    drive(5, 0, 1, 0, 0, 5, 5, 0, 0);

    // Stall hold for three cycles with changing EX inputs
    drive(12, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(13, 1, 1, 12, 0, 0, 0, 1, 0);
    drive(14, 0, 1, 0, 12, 0, 0, 1, 1);
    drive(15, 1, 0, 12, 12, 0, 0, 1, 0);
    drive(16, 1, 0, 12, 0, 0, 0, 0, 0);
    drive(17, 1, 0, 0, 0, 0, 0, 0, 0);

    // Flush alone, Stall with Flush, then Flush held after Stall drops
    drive(20, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(21, 1, 1, 20, 0, 0, 0, 0, 1);
    drive(22, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(23, 1, 0, 22, 22, 0, 0, 1, 1);
    drive(23, 1, 0, 22, 0, 0, 0, 0, 1);
    drive(24, 1, 0, 0, 0, 0, 0, 0, 0);

    // Random run over a small register range so matches are frequent
    for (int i = 0; i < 60; i++) begin
      drive(REG_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
            REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    if (exp_q.size() != 0) check_val("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
